// File: rtl/core_pkg.sv
// Shared core constants and types used by the execute-stage multiplier.
package core_pkg;

  localparam int XLEN               = 32;
  localparam int MUL_BITS_PER_CYCLE = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One multiply iteration: accumulate a times a narrow multiplier chunk, mod 2^XLEN.
module mul_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic [XLEN-1:0]           acc,
  input  logic [XLEN-1:0]           a,
  input  logic [BITS_PER_CYCLE-1:0] b_chunk,
  output logic [XLEN-1:0]           sum
);

  logic [XLEN-1:0] bExt;

  always_comb begin
    bExt                       = '0;
    bExt[BITS_PER_CYCLE-1:0]   = b_chunk;
    sum                        = acc + a * bExt;
  end

endmodule

// File: rtl/mul_stall_unit.sv
// Iterative low-half multiplier in Execute; stalls F/D/E while computing and
// keeps the finished result presented for as long as the data cache holds the pipe.
module mul_stall_unit
  import core_pkg::*;
#(
  parameter int XLEN           = core_pkg::XLEN,
  parameter int BITS_PER_CYCLE = core_pkg::MUL_BITS_PER_CYCLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            mul_stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  mul_state_t      state, nextState;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc, aReg, bReg, stepSum;

  mul_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) uStep (
    .acc    (acc),
    .a      (aReg),
    .b_chunk(bReg[BITS_PER_CYCLE-1:0]),
    .sum    (stepSum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      aReg  <= '0;
      bReg  <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            aReg  <= op_a;
            bReg  <= op_b;
            acc   <= '0;
            count <= CW'(N - 1);
          end
        end
        BUSY: begin
          if (!abort) begin
            acc   <= stepSum;
            aReg  <= aReg << BITS_PER_CYCLE;
            bReg  <= bReg >> BITS_PER_CYCLE;
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // DONE deliberately ignores start: the finished MUL is still sitting in E.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && !abort) nextState = BUSY;
      BUSY: begin
        if (abort)            nextState = IDLE;
        else if (count == '0) nextState = DONE;
      end
      DONE:    if (abort || !hold) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    mul_stall    = 1'b0;
    result_valid = 1'b0;
    result       = acc;
    case (state)
      IDLE:    mul_stall    = start && !abort;
      BUSY:    mul_stall    = !abort;
      DONE:    result_valid = !abort;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_stall_unit.sv
// Self-checking bench for mul_stall_unit: directed scenarios plus randomized
// operations compared against a transaction-level timing and product model.
module tb_mul_stall_unit;

  localparam int XLEN = 32;
  localparam int BPC  = 8;
  localparam int N    = XLEN / BPC;

  logic            clk = 1'b0;
  logic            rst, start, abort, hold;
  logic [XLEN-1:0] opA, opB, result;
  logic            mulStall, resultValid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_stall_unit #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .op_a        (opA),
    .op_b        (opB),
    .mul_stall   (mulStall),
    .result      (result),
    .result_valid(resultValid)
  );

  task automatic checkVal(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] refMul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    return p[XLEN-1:0];
  endfunction

  // Apply one cycle's inputs away from the active edge, then let comb outputs settle.
  task automatic drive(input logic r, input logic s, input logic ab, input logic h,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    rst = r; start = s; abort = ab; hold = h; opA = a; opB = b;
    #1;
  endtask

  task automatic idleCycle(input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    checkVal({tag, "_idle_stall"}, {31'b0, mulStall}, '0);
    checkVal({tag, "_idle_valid"}, {31'b0, resultValid}, '0);
  endtask

  // One MUL as seen from E: start held from issue until the pipe advances.
  // Model: stall for N+1 cycles, then valid for 1+holdN cycles; abort kills it.
  task automatic runOp(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int holdN, input int abortAt);
    int last;
    logic [XLEN-1:0] exp;
    exp  = refMul(a, b);
    last = (abortAt >= 0) ? abortAt : N + 1 + holdN;
    for (int c = 0; c <= last; c++) begin
      logic h;
      h = (c >= N + 1) && (c < N + 1 + holdN);
      if (c == 0) drive(1'b0, 1'b1, abortAt == 0, h, a, b);
      else        drive(1'b0, 1'b1, c == abortAt, h, $urandom, $urandom);
      if (abortAt >= 0 && c >= abortAt) begin
        checkVal($sformatf("%s_abort_stall_c%0d", tag, c), {31'b0, mulStall}, '0);
        checkVal($sformatf("%s_abort_valid_c%0d", tag, c), {31'b0, resultValid}, '0);
      end else begin
        checkVal($sformatf("%s_stall_c%0d", tag, c), {31'b0, mulStall}, (c <= N) ? 1 : 0);
        checkVal($sformatf("%s_valid_c%0d", tag, c), {31'b0, resultValid}, (c > N) ? 1 : 0);
        if (c > N) checkVal($sformatf("%s_result_c%0d", tag, c), result, exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; opA = '0; opB = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    checkVal("reset_stall", {31'b0, mulStall}, '0);
    checkVal("reset_valid", {31'b0, resultValid}, '0);
    checkVal("reset_result", result, '0);

    runOp("basic", 32'd7, 32'd6, 0, -1);
    idleCycle("basic");
    runOp("wrap1", 32'hFFFF_FFFF, 32'd2, 0, -1);
    runOp("wrap2", 32'h8000_0000, 32'd2, 0, -1);
    idleCycle("wrap");
    runOp("hold", 32'd7, 32'd6, 3, -1);
    idleCycle("hold");
    runOp("abortBusy", 32'd7, 32'd6, 0, 2);
    idleCycle("abortBusy");
    runOp("abortDoneHold", 32'd11, 32'd13, 3, N + 2);
    idleCycle("abortDoneHold");
    runOp("b2b1", 32'd3, 32'd5, 0, -1);
    runOp("b2b2", 32'h0001_0000, 32'h0001_0000, 0, -1);
    idleCycle("b2b");
    runOp("zeros", 32'd0, 32'd0, 0, -1);
    runOp("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1);
    idleCycle("edge");

    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd6);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 32'd4);
    checkVal("rstMid_stall", {31'b0, mulStall}, '0);
    checkVal("rstMid_valid", {31'b0, resultValid}, '0);
    checkVal("rstMid_result", result, '0);
    runOp("postRst", 32'd9, 32'd9, 0, -1);
    idleCycle("postRst");

    for (int i = 0; i < 60; i++) begin
      logic [XLEN-1:0] a, b;
      int holdN, abortAt;
      case ($urandom_range(0, 5))
        0:       a = '0;
        1:       a = '1;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 5) == 0) ? '1 : $urandom;
      holdN   = $urandom_range(0, 3);
      abortAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N + 1 + holdN) : -1;
      runOp($sformatf("rnd%0d", i), a, b, holdN, abortAt);
      if (abortAt >= 0 || $urandom_range(0, 1) == 1) idleCycle($sformatf("rnd%0d", i));
    end

    idleCycle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
